// File: rtl/forward_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | forward_unit_pkg                                                 |
// | Shared pipeline encodings: operand select, source usage, entries.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package forward_unit_pkg;

  localparam int c_REG_W = 5;

  // Operand-mux select, shared with the datapath muxes and hazard logic
  localparam logic [1:0] c_FWD_REGFILE = 2'b00;
  localparam logic [1:0] c_FWD_MEM     = 2'b01;
  localparam logic [1:0] c_FWD_WB      = 2'b10;

  // Decode-stage source usage (reg_RD)
  localparam logic [1:0] c_USE_NONE = 2'b00;
  localparam logic [1:0] c_USE_RS1  = 2'b01;
  localparam logic [1:0] c_USE_RS2  = 2'b10;

  typedef logic [c_REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     we;
    reg_idx_t rd;
    logic     ld;
  } trk_t;

  typedef struct packed {
    trk_t     trk;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic [1:0] rd_use;
  } e_entry_t;

  localparam trk_t c_TRK_BUBBLE = '0;
  localparam e_entry_t c_E_BUBBLE = '{trk: c_TRK_BUBBLE, rs1: '0, rs2: '0, rd_use: c_USE_NONE};

  function automatic logic src_hit(input logic [1:0] rd_use, input logic [1:0] mask,
                                   input reg_idx_t src, input reg_idx_t dst);
    return (|(rd_use & mask)) && (src == dst);
  endfunction

endpackage
`default_nettype wire

// File: rtl/forward_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | forward_unit_if                                                  |
// | Decode-stage hazard inputs and E-stage forwarding outputs.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface forward_unit_if #(
  parameter int CNT_W = 16
);
  import forward_unit_pkg::*;

  logic             reg_WE;
  logic             is_load;
  logic [1:0]       reg_RD;
  reg_idx_t         rs1;
  reg_idx_t         rs2;
  reg_idx_t         rd;
  logic             stall_E;
  logic             flush_E;
  logic             flush_M;
  logic [1:0]       fwd_A;
  logic [1:0]       fwd_B;
  logic             load_use_stall;
  logic [CNT_W-1:0] lu_count;

  modport master (
    output reg_WE, is_load, reg_RD, rs1, rs2, rd, stall_E, flush_E, flush_M,
    input  fwd_A, fwd_B, load_use_stall, lu_count
  );

  modport slave (
    input  reg_WE, is_load, reg_RD, rs1, rs2, rd, stall_E, flush_E, flush_M,
    output fwd_A, fwd_B, load_use_stall, lu_count
  );

endinterface
`default_nettype wire

// File: rtl/forward_unit_fwd_compare.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fwd_compare                                                      |
// | One operand's forwarding select; M beats WB, x0 never forwards.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fwd_compare
  import forward_unit_pkg::*;
(
  input  logic       i_use,
  input  reg_idx_t   i_src,
  input  logic       i_m_we,
  input  reg_idx_t   i_m_rd,
  input  logic       i_wb_we,
  input  reg_idx_t   i_wb_rd,
  output logic [1:0] o_sel
);

  logic w_active;

  assign w_active = i_use && (i_src != '0);

  always_comb begin
    o_sel = c_FWD_REGFILE;
    if (w_active) begin
      if (i_m_we && (i_m_rd == i_src)) begin
        o_sel = c_FWD_MEM;
      end else if (i_wb_we && (i_wb_rd == i_src)) begin
        o_sel = c_FWD_WB;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | forward_unit                                                     |
// | E/M/WB write tracking, operand forwarding and load-use stalls.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module forward_unit
  import forward_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  forward_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  e_entry_t         r_e;
  trk_t             r_m;
  trk_t             r_wb;
  logic [CNT_W-1:0] r_lu_count;

  e_entry_t w_dec;
  logic     w_lu_src;
  logic     w_lu_stall;

  always_comb begin
    w_dec        = c_E_BUBBLE;
    w_dec.trk.we = bus.reg_WE;
    w_dec.trk.rd = bus.rd;
    w_dec.trk.ld = bus.is_load;
    w_dec.rs1    = bus.rs1;
    w_dec.rs2    = bus.rs2;
    w_dec.rd_use = bus.reg_RD;
  end

  // Decode consumer against the load sitting in E (held entry under stall_E)
  assign w_lu_src   = src_hit(bus.reg_RD, c_USE_RS1, bus.rs1, r_e.trk.rd)
                    | src_hit(bus.reg_RD, c_USE_RS2, bus.rs2, r_e.trk.rd);
  assign w_lu_stall = r_e.trk.ld & r_e.trk.we & (r_e.trk.rd != '0) & w_lu_src & ~bus.flush_E;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e <= c_E_BUBBLE;
    end else if (bus.flush_E) begin
      r_e <= c_E_BUBBLE;
    end else if (bus.stall_E) begin
      r_e <= r_e;
    end else if (w_lu_stall) begin
      r_e <= c_E_BUBBLE;
    end else begin
      r_e <= w_dec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m <= c_TRK_BUBBLE;
    end else if (bus.flush_M) begin
      r_m <= c_TRK_BUBBLE;
    end else if (bus.stall_E) begin
      r_m <= r_m;
    end else begin
      r_m <= r_e.trk;
    end
  end

  // WB takes the pre-flush M contents
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb <= c_TRK_BUBBLE;
    end else if (bus.stall_E) begin
      r_wb <= r_wb;
    end else begin
      r_wb <= r_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lu_count <= '0;
    end else if (w_lu_stall && !bus.stall_E && (r_lu_count != c_CNT_MAX)) begin
      r_lu_count <= r_lu_count + c_CNT_ONE;
    end
  end

  fwd_compare u_cmp_a (
    .i_use   (|(r_e.rd_use & c_USE_RS1)),
    .i_src   (r_e.rs1),
    .i_m_we  (r_m.we),
    .i_m_rd  (r_m.rd),
    .i_wb_we (r_wb.we),
    .i_wb_rd (r_wb.rd),
    .o_sel   (bus.fwd_A)
  );

  fwd_compare u_cmp_b (
    .i_use   (|(r_e.rd_use & c_USE_RS2)),
    .i_src   (r_e.rs2),
    .i_m_we  (r_m.we),
    .i_m_rd  (r_m.rd),
    .i_wb_we (r_wb.we),
    .i_wb_rd (r_wb.rd),
    .o_sel   (bus.fwd_B)
  );

  assign bus.load_use_stall = w_lu_stall;
  assign bus.lu_count       = r_lu_count;

endmodule
`default_nettype wire

// File: tb/tb_forward_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_forward_unit                                                  |
// | Directed and random pipeline traffic against a stage-array model.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_forward_unit;

  typedef struct packed {
    bit       we;
    bit       ld;
    bit [1:0] srcs;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
  } ins_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  forward_unit_if #(.CNT_W(16)) bus ();
  forward_unit_if #(.CNT_W(3))  bus_s ();

  forward_unit #(.CNT_W(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  forward_unit #(.CNT_W(3))  dut_s (.clk(clk), .reset_n(reset_n), .bus(bus_s));

  assign bus_s.reg_WE  = bus.reg_WE;
  assign bus_s.is_load = bus.is_load;
  assign bus_s.reg_RD  = bus.reg_RD;
  assign bus_s.rs1     = bus.rs1;
  assign bus_s.rs2     = bus.rs2;
  assign bus_s.rd      = bus.rd;
  assign bus_s.stall_E = bus.stall_E;
  assign bus_s.flush_E = bus.flush_E;
  assign bus_s.flush_M = bus.flush_M;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: in-flight instructions by stage, plus raw bubble count
  ins_t        st_e, st_m, st_wb;
  int unsigned lu_model;

  task automatic model_reset();
    st_e = '0; st_m = '0; st_wb = '0; lu_model = 0;
  endtask

  function automatic logic [1:0] exp_fwd(input bit used, input bit [4:0] src);
    if (!used || src == 5'd0) return 2'b00;
    if (st_m.we && st_m.rd == src) return 2'b01;
    if (st_wb.we && st_wb.rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit exp_stall();
    bit reads;
    reads = (bus.reg_RD[0] && bus.rs1 == st_e.rd) || (bus.reg_RD[1] && bus.rs2 == st_e.rd);
    return st_e.ld && st_e.we && (st_e.rd != 5'd0) && reads && !bus.flush_E;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit we, input bit ld, input bit [1:0] srcs, input bit [4:0] s1,
                       input bit [4:0] s2, input bit [4:0] d, input bit stl, input bit fe,
                       input bit fm);
    bus.reg_WE = we; bus.is_load = ld; bus.reg_RD = srcs;
    bus.rs1 = s1; bus.rs2 = s2; bus.rd = d;
    bus.stall_E = stl; bus.flush_E = fe; bus.flush_M = fm;
  endtask

  task automatic compare_all();
    check("fwd_A", 32'(bus.fwd_A), 32'(exp_fwd(st_e.srcs[0], st_e.rs1)));
    check("fwd_B", 32'(bus.fwd_B), 32'(exp_fwd(st_e.srcs[1], st_e.rs2)));
    check("load_use_stall", 32'(bus.load_use_stall), 32'(exp_stall()));
    check("lu_count", 32'(bus.lu_count), (lu_model > 65535) ? 32'd65535 : lu_model);
    check("lu_count_sat3", 32'(bus_s.lu_count), (lu_model > 7) ? 32'd7 : lu_model);
  endtask

  task automatic step(input bit we, input bit ld, input bit [1:0] srcs, input bit [4:0] s1,
                      input bit [4:0] s2, input bit [4:0] d, input bit stl, input bit fe,
                      input bit fm);
    ins_t dec, n_e, n_m, n_wb;
    bit   lu;
    drive(we, ld, srcs, s1, s2, d, stl, fe, fm);
    #1;
    compare_all();
    lu  = exp_stall();
    dec = '{we: we, ld: ld, srcs: srcs, rs1: s1, rs2: s2, rd: d};
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      n_wb = stl ? st_wb : st_m;
      n_m  = fm ? ins_t'(0) : (stl ? st_m : st_e);
      n_e  = fe ? ins_t'(0) : (stl ? st_e : (lu ? ins_t'(0) : dec));
      if (lu && !stl) lu_model++;
      st_e = n_e; st_m = n_m; st_wb = n_wb;
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0;
    model_reset();
    drive(1, 1, 2'b11, 5'd3, 5'd3, 5'd3, 0, 0, 0);
    #1;
    check("rst_fwd_A", 32'(bus.fwd_A), 32'd0);
    check("rst_fwd_B", 32'(bus.fwd_B), 32'd0);
    check("rst_stall", 32'(bus.load_use_stall), 32'd0);
    check("rst_count", 32'(bus.lu_count), 32'd0);
    @(negedge clk);
    step(1, 1, 2'b00, 5'd0, 5'd0, 5'd3, 0, 0, 0);
    step(1, 0, 2'b11, 5'd3, 5'd3, 5'd4, 0, 0, 0);
    reset_n = 1'b1;

    // ALU producer directly followed by consumer
    step(1, 0, 2'b00, 5'd0, 5'd0, 5'd5, 0, 0, 0);
    step(1, 0, 2'b01, 5'd5, 5'd0, 5'd6, 0, 0, 0);
    check("alu_next_fwd_A", 32'(bus.fwd_A), 32'd1);

    // one and two instructions of distance
    step(1, 0, 2'b00, 5'd0, 5'd0, 5'd5, 0, 0, 0);
    step(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(1, 0, 2'b10, 5'd0, 5'd5, 5'd7, 0, 0, 0);
    check("dist2_fwd_B", 32'(bus.fwd_B), 32'd2);
    step(1, 0, 2'b00, 5'd0, 5'd0, 5'd5, 0, 0, 0);
    step(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(1, 0, 2'b10, 5'd0, 5'd5, 5'd7, 0, 0, 0);
    check("dist3_fwd_B", 32'(bus.fwd_B), 32'd0);

    // load followed by consumer: one bubble then WB forward
    step(1, 1, 2'b00, 5'd0, 5'd0, 5'd7, 0, 0, 0);
    drive(1, 0, 2'b01, 5'd7, 5'd0, 5'd8, 0, 0, 0);
    #1;
    check("lu_stall_on", 32'(bus.load_use_stall), 32'd1);
    check("lu_count_before", 32'(bus.lu_count), 32'd0);
    step(1, 0, 2'b01, 5'd7, 5'd0, 5'd8, 0, 0, 0);
    drive(1, 0, 2'b01, 5'd7, 5'd0, 5'd8, 0, 0, 0);
    #1;
    check("lu_stall_off", 32'(bus.load_use_stall), 32'd0);
    check("lu_count_after", 32'(bus.lu_count), 32'd1);
    step(1, 0, 2'b01, 5'd7, 5'd0, 5'd8, 0, 0, 0);
    check("lu_consumer_fwd_A", 32'(bus.fwd_A), 32'd2);

    // x0 never forwards or stalls
    step(1, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    step(1, 0, 2'b11, 5'd0, 5'd0, 5'd9, 0, 0, 0);
    check("x0_fwd_A", 32'(bus.fwd_A), 32'd0);
    check("x0_fwd_B", 32'(bus.fwd_B), 32'd0);
    step(1, 1, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 0, 2'b01, 5'd0, 5'd0, 5'd9, 0, 0, 0);
    #1;
    check("x0_load_stall", 32'(bus.load_use_stall), 32'd0);
    step(1, 0, 2'b01, 5'd0, 5'd0, 5'd9, 0, 0, 0);

    // flush_E wins over load-use
    step(1, 1, 2'b00, 5'd0, 5'd0, 5'd9, 0, 0, 0);
    drive(1, 0, 2'b01, 5'd9, 5'd0, 5'd10, 0, 1, 0);
    #1;
    check("flushE_no_stall", 32'(bus.load_use_stall), 32'd0);
    step(1, 0, 2'b01, 5'd9, 5'd0, 5'd10, 0, 1, 0);
    drive(1, 0, 2'b01, 5'd9, 5'd0, 5'd10, 0, 0, 0);
    #1;
    check("flushE_e_empty", 32'(bus.load_use_stall), 32'd0);
    check("flushE_count", 32'(bus.lu_count), 32'd1);
    step(1, 0, 2'b01, 5'd9, 5'd0, 5'd10, 0, 0, 0);

    // stall_E keeps the load in E and the request asserted
    step(1, 1, 2'b00, 5'd0, 5'd0, 5'd11, 0, 0, 0);
    drive(1, 0, 2'b10, 5'd0, 5'd11, 5'd12, 1, 0, 0);
    #1;
    check("stallE_lu_on", 32'(bus.load_use_stall), 32'd1);
    step(1, 0, 2'b10, 5'd0, 5'd11, 5'd12, 1, 0, 0);
    step(1, 0, 2'b10, 5'd0, 5'd11, 5'd12, 0, 0, 0);
    step(1, 0, 2'b10, 5'd0, 5'd11, 5'd12, 0, 0, 0);

    // async reset with three writers in flight
    step(1, 0, 2'b00, 5'd0, 5'd0, 5'd1, 0, 0, 0);
    step(1, 0, 2'b00, 5'd0, 5'd0, 5'd2, 0, 0, 0);
    step(1, 0, 2'b11, 5'd2, 5'd1, 5'd3, 0, 0, 0);
    check("pre_rst_fwd_A", 32'(bus.fwd_A), 32'd1);
    check("pre_rst_fwd_B", 32'(bus.fwd_B), 32'd2);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_fwd_A", 32'(bus.fwd_A), 32'd0);
    check("async_rst_fwd_B", 32'(bus.fwd_B), 32'd0);
    check("async_rst_count", 32'(bus.lu_count), 32'd0);
    @(negedge clk);
    step(1, 0, 2'b00, 5'd0, 5'd0, 5'd4, 0, 0, 0);
    reset_n = 1'b1;
    step(1, 0, 2'b00, 5'd0, 5'd0, 5'd4, 0, 0, 0);
    step(1, 0, 2'b01, 5'd4, 5'd0, 5'd5, 0, 0, 0);
    check("post_rst_capture", 32'(bus.fwd_A), 32'd1);

    // enough load-use events to saturate the 3-bit counter
    for (int k = 0; k < 9; k++) begin
      step(1, 1, 2'b00, 5'd0, 5'd0, 5'd3, 0, 0, 0);
      step(1, 0, 2'b01, 5'd3, 5'd0, 5'd6, 0, 0, 0);
      step(1, 0, 2'b01, 5'd3, 5'd0, 5'd6, 0, 0, 0);
    end
    check("sat3_count", 32'(bus_s.lu_count), 32'd7);
    check("full_count", 32'(bus.lu_count), 32'd9);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), bit'($urandom_range(0, 7) == 0),
           bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/forward_unit.md
FORWARD_UNIT -- requirements
Module: forward_unit

Interface
REQ-001 Parameter CNT_W, default 16, width of the load-use stall counter.
REQ-002 clk  input  1  pipeline clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 reg_WE  input  1  decode-stage instruction writes rd.
REQ-005 is_load  input  1  decode-stage instruction is a load; its result is available only in WB.
REQ-006 reg_RD  input  2  decode-stage source usage: 00 none, 01 rs1, 10 rs2, 11 rs1 and rs2.
REQ-007 rs1, rs2, rd  input  5 each  decode-stage register indices.
REQ-008 stall_E  input  1  freezes the E, M and WB tracking entries.
REQ-009 flush_E, flush_M  input  1 each  convert the E or M entry into a bubble.
REQ-010 fwd_A, fwd_B  output  2 each  E-stage operand select: 00 regfile, 01 M-stage ALU result, 10 WB-stage result, 11 never driven.
REQ-011 load_use_stall  output  1  request to stall F/D and insert a bubble into E.
REQ-012 lu_count  output  CNT_W  number of load-use bubbles inserted, saturating.

Function
REQ-013 The block SHALL keep three tracking entries (E, M, WB), each holding we, rd[4:0] and ld; the E entry also holds rs1, rs2 and reg_RD.
REQ-014 Per rising edge, each entry SHALL apply the first matching rule: reset, then flush (clear), then stall_E (hold), then bubble, then advance.
REQ-015 A bubble SHALL have we=0, ld=0, reg_RD=00 and all indices zero.
REQ-016 On advance: E SHALL capture the decode inputs, M SHALL capture E, and WB SHALL capture M.
REQ-017 When load_use_stall=1 and stall_E=0, E SHALL capture a bubble while M and WB advance.
REQ-018 flush_M SHALL clear M only; WB SHALL still capture the pre-flush M contents on the same edge.
REQ-019 fwd_A SHALL be combinational from current entries:
 - 01 if E.reg_RD[0], M.we, M.rd==E.rs1 and E.rs1!=0;
 - else 10 if WB.we, WB.rd==E.rs1 and E.rs1!=0;
 - else 00.
REQ-020 fwd_B SHALL follow REQ-019 using E.reg_RD[1] and E.rs2.
REQ-021 M SHALL take priority over WB when both match; register x0 SHALL never forward.
REQ-022 load_use_stall SHALL equal E.ld & E.we & (E.rd!=0) & ((reg_RD[0] & rs1==E.rd) | (reg_RD[1] & rs2==E.rd)) & ~flush_E.
REQ-023 Under stall_E, load_use_stall SHALL remain computed from the held E entry.
REQ-024 A load with its consumer in the next instruction SHALL cost exactly one bubble; the consumer then receives fwd=10 in E.
REQ-025 lu_count SHALL increment by one on each edge where a bubble is inserted per REQ-017, and SHALL hold at all-ones.
REQ-026 flush_E coinciding with a load-use condition SHALL flush E, assert no stall and leave the count unchanged.
REQ-027 The block SHALL NOT write to or read from the register file; it has no same-cycle write-through path.

Reset
REQ-028 While reset_n=0, all entries SHALL be bubbles, lu_count=0, fwd_A=fwd_B=00 and load_use_stall=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries immediately, independent of clk.
REQ-030 The first edge after reset_n rises SHALL capture decode inputs normally.

Structure
REQ-031 The fwd select encodings (00/01/10) and the reg_RD encoding SHALL be localparams in the shared pipeline package, also used by the datapath operand muxes and the hazard block.
REQ-032 One sub-module, fwd_compare, SHALL compute a single 2-bit select from (use, src, M.we, M.rd, WB.we, WB.rd); it SHALL be instantiated twice.
REQ-033 All other logic SHALL be flat within forward_unit.

Verification
REQ-034 add x5 ← ALU, then add x6 uses rs1=x5 -> fwd_A=01 in the cycle x6 is in E.
REQ-035 add x5, nop, sub uses rs2=x5 -> fwd_B=10 when sub is in E; a second nop -> 00.
REQ-036 lw x7, then add uses rs1=x7 -> load_use_stall=1 for one cycle, bubble in E, add then sees fwd_A=10, lu_count 0→1.
REQ-037 Producer writes x0, consumer reads x0 -> fwd 00 and no stall.
REQ-038 Load-use condition with flush_E=1 on the same cycle -> no stall, E empty, count unchanged; preload lu_count to 0xFFFF, then a load-use event -> stays 0xFFFF.
REQ-039 reset_n pulsed low mid-stream with three writers in flight -> all selects 00 and lu_count=0 before the next clk edge.
